// File: rtl/hdmi_signal_pipe.sv
// hdmi_signal_pipe: pixel source select (passthrough / solid / colour bars /
// blank) followed by a matched register pipeline for the HDMI transmitter.
// Mode switches only on a rising in_v_sync so a frame never mixes sources.
module hdmi_signal_pipe #(
  parameter int COLOR_W    = 8,
  parameter int PIPE_DEPTH = 2,
  parameter int BAR_W      = 80,
  parameter int CNT_W      = 12,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLOR_W-1:0]     r,
  input  logic [COLOR_W-1:0]     g,
  input  logic [COLOR_W-1:0]     b,
  input  logic                   in_h_sync,
  input  logic                   in_v_sync,
  input  logic                   in_data_en,
  input  logic [1:0]             mode_req,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic [3*COLOR_W-1:0]   data,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   data_en,
  output logic                   clk_out,
  output logic [1:0]             mode_active,
  output logic [15:0]            frame_cnt
);

  localparam int PW = 3 * COLOR_W;

  logic [CNT_W-1:0] pix;
  logic [2:0]       bar;
  logic [2:0]       bar_code;
  logic [PW-1:0]    bar_rgb;
  logic [PW-1:0]    sel_rgb;
  logic             vs_prev;
  logic             frame_evt;

  logic [PW-1:0]         rgb_q [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] de_q;
  logic [PIPE_DEPTH-1:0] hs_q;
  logic [PIPE_DEPTH-1:0] vs_q;

  // History starts at 1 after reset so a vsync already high is not a new frame.
  assign frame_evt = in_v_sync & ~vs_prev;

  // Bar 0 is white; code counts down so the sequence ends on black.
  assign bar_code = 3'd7 - bar;
  assign bar_rgb  = {{COLOR_W{bar_code[2]}}, {COLOR_W{bar_code[1]}}, {COLOR_W{bar_code[0]}}};

  // Track vsync history, latch the requested mode and count frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_prev     <= 1'b1;
      mode_active <= 2'd0;
      frame_cnt   <= 16'd0;
    end else begin
      vs_prev <= in_v_sync;
      if (frame_evt) begin
        mode_active <= mode_req;
        frame_cnt   <= frame_cnt + 16'd1;
      end
    end
  end

  // Pixel-in-bar and bar index; run in every mode, restart on each blank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix <= '0;
      bar <= 3'd0;
    end else if (in_data_en) begin
      if (pix == CNT_W'(BAR_W - 1)) begin
        pix <= '0;
        bar <= bar + 3'd1;
      end else begin
        pix <= pix + CNT_W'(1);
      end
    end else begin
      pix <= '0;
      bar <= 3'd0;
    end
  end

  // Source select; uses the mode in force before any same-cycle frame event.
  always_comb begin
    sel_rgb = '0;
    if (in_data_en) begin
      case (mode_active)
        2'd0:    sel_rgb = {r, g, b};
        2'd1:    sel_rgb = solid_rgb;
        2'd2:    sel_rgb = bar_rgb;
        default: sel_rgb = '0;
      endcase
    end
  end

  // Matched delay line: stage 0 captures, later stages only shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        rgb_q[i] <= '0;
      end
      de_q <= '0;
      hs_q <= '0;
      vs_q <= '0;
    end else begin
      rgb_q[0] <= sel_rgb;
      de_q[0]  <= in_data_en;
      hs_q[0]  <= in_h_sync;
      vs_q[0]  <= in_v_sync;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        rgb_q[i] <= rgb_q[i-1];
        de_q[i]  <= de_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
      end
    end
  end

  assign data    = rgb_q[PIPE_DEPTH-1];
  assign data_en = de_q[PIPE_DEPTH-1];
  assign h_sync  = hs_q[PIPE_DEPTH-1] ^ HS_POL;
  assign v_sync  = vs_q[PIPE_DEPTH-1] ^ VS_POL;
  assign clk_out = ~clk;

endmodule

// File: doc/hdmi_signal_pipe.md
Name: hdmi_signal_pipe

Overview:
Parametrised successor to the HDMI output register stage. It takes pixel colour and the sync/DE timing from HDMI control, selects the pixel source per mode (passthrough, solid colour, colour bars, blank), and delays everything through a configurable matched pipeline. It outputs the bus for the HDMI transmitter. Mode changes are frame-synchronous, and a frame counter is provided for software and debug.

Parameters:
COLOR_W, 8, bits per colour channel (>=1)
PIPE_DEPTH, 2, total register stages input->output (1..8)
BAR_W, 80, pixels per colour bar in mode 2 (>=1)
CNT_W, 12, width of the internal pixel-in-bar counter (2^CNT_W > BAR_W)
HS_POL, 0, 1 = invert h_sync at output
VS_POL, 0, 1 = invert v_sync at output

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-low reset
r  in  COLOR_W  red input
g  in  COLOR_W  green input
b  in  COLOR_W  blue input
in_h_sync  in  1  hsync from HDMI control, active-high
in_v_sync  in  1  vsync from HDMI control, active-high
in_data_en  in  1  active video from HDMI control
mode_req  in  2  requested mode: 0 pass, 1 solid, 2 bars, 3 blank
solid_rgb  in  3*COLOR_W  solid colour {r,g,b}, sampled every pixel
data  out  3*COLOR_W  {r,g,b} pixel to transmitter
h_sync  out  1  delayed hsync, polarity per HS_POL
v_sync  out  1  delayed vsync, polarity per VS_POL
data_en  out  1  delayed data enable
clk_out  out  1  inverted clk (combinational, ~clk)
mode_active  out  2  mode currently applied
frame_cnt  out  16  count of vsync rising edges, wraps

Behaviour:
- Reset (rst=0, async): all pipeline stages clear. Outputs go to data=0, data_en=0, h_sync=HS_POL, v_sync=VS_POL, mode_active=0, frame_cnt=0. Internal bar counters clear to 0. The vsync history register is set to 1, so no edge is detected on the first cycle after reset. Reset mid-frame discards all in-flight pixels.
- Latency: data, data_en, h_sync and v_sync all take exactly PIPE_DEPTH cycles from input to output and stay mutually aligned.
- Stage 0 (input side) registers the selected pixel, DE and syncs. Stages 1..PIPE_DEPTH-1 are pure delay.
- Sync polarity: h_sync = delayed(in_h_sync) XOR HS_POL; v_sync = delayed(in_v_sync) XOR VS_POL.
- Frame event: in_v_sync=1 on a cycle where the previous sampled in_v_sync was 0.
  - On that clock edge, mode_active <= mode_req and frame_cnt <= frame_cnt+1 (0xFFFF -> 0).
  - The new mode applies to pixels sampled from the next cycle onward.
  - mode_req changes at any other time have no effect.
- Pixel selection at stage 0:
  - If in_data_en=0, data=0 regardless of mode.
  - Otherwise, per mode_active:
    - 0: {r,g,b}
    - 1: solid_rgb
    - 2: colour bar (below)
    - 3: all zeros
- Colour bars:
  - Counters: pix (CNT_W bits) and bar (3 bits).
  - While in_data_en=1: if pix==BAR_W-1, then pix<=0 and bar<=bar+1 (7 -> 0 wraps); else pix<=pix+1.
  - When in_data_en=0: pix<=0 and bar<=0, so every line starts at bar 0.
  - The counters run in all modes.
  - Colour code c = 7-bar. Each channel is all-ones if its bit is set, else 0: red=c[2], green=c[1], blue=c[0].
  - Resulting order: white, yellow, magenta, red, cyan, green, blue, black.
  - The pixel at line position 0 uses bar 0. Counters advance after use.
- Simultaneous events: a frame event and in_data_en=1 on the same cycle → that pixel uses the old mode_active.
- No divider; all arithmetic is fixed width with natural wrap except where stated.

Test Plan:
1. Reset mid-stream: drive 10 DE pixels, assert rst=0 asynchronously → data=0, data_en=0, h_sync=HS_POL, v_sync=VS_POL, frame_cnt=0 immediately, with no clock needed.
2. Passthrough latency, PIPE_DEPTH=3: r,g,b=0x12,0x34,0x56 with DE=1 at cycle N → data=0x123456 and data_en=1 at cycle N+3; hs/vs pulses appear 3 cycles later.
3. Frame-synchronous mode: set mode_req=1 (solid_rgb=0xA0B0C0) mid-line → output unchanged until the next vsync rise; first DE pixel after it → 0xA0B0C0; mode_active=1; frame_cnt +1.
4. Colour bars, BAR_W=4, 40-pixel line → 4 pixels each of FFFFFF, FFFF00, FF00FF, FF0000, 00FFFF, 00FF00, 0000FF, 000000, then FFFFFF×4 and FFFF00×4 (wrap); next line restarts with FFFFFF.
5. Blanking/polarity, HS_POL=1, mode 1: DE=0 with in_h_sync=1 → data=0, h_sync=0; mode 3 with DE=1 → data=0, data_en=1.
6. Frame counter wrap: preload via 65536 vsync rises → frame_cnt returns to 0x0000; a vsync held high for multiple cycles counts once.
